// File: rtl/debounce_pkg.sv
// Shared constants and types for the multi-channel push-button debouncer.
package debounce_pkg;

  localparam int unsigned MAX_CHANNELS      = 32;
  localparam int unsigned DEF_CHANNELS      = 4;
  localparam int unsigned DEF_CLK_DIV       = 100_000;
  localparam int unsigned DEF_STABLE_TICKS  = 20;
  localparam int unsigned DEF_REPEAT_DELAY  = 500;
  localparam int unsigned DEF_REPEAT_PERIOD = 100;

  typedef logic [MAX_CHANNELS-1:0] btn_vec_t;

  // Counter width able to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Shared sample-tick generator: one-cycle registered pulse every CLK_DIV clk_in cycles.
module debounce_tick_gen
  import debounce_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d    = 1'b0;
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      tick_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/multi_debounce.sv
// N-channel push-button conditioner: synchroniser, tick-sampled stability filter, press/release pulses.
// Optional auto-repeat on held buttons is enabled by defining DEBOUNCE_REPEAT_EN.
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = DEF_CHANNELS,
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned STABLE_TICKS  = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] pb_in,
  output logic [CHANNELS-1:0] db_level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                tick_out
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = cnt_width(REP_MAX);
  localparam logic [REP_W-1:0] REP_DELAY_C  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD_C = REP_W'(REPEAT_PERIOD);
`endif

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS || CLK_DIV < 2 || STABLE_TICKS < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("multi_debounce: illegal parameter combination");
  end

  logic tick;

  debounce_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  assign tick_out = tick;

  logic [CHANNELS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pb_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             flip;
    logic             rep_fire;

    // The filter only advances on tick cycles; between ticks all state holds.
    always_comb begin
      stab_cnt_d = stab_cnt_q;
      level_d    = level_q;
      flip       = 1'b0;
      if (tick) begin
        if (sync2_q[i] == level_q) begin
          stab_cnt_d = '0;
        end else if (stab_cnt_q == CNT_LAST) begin
          stab_cnt_d = '0;
          level_d    = sync2_q[i];
          flip       = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      press_d   = (flip & sync2_q[i]) | rep_fire;
      release_d = flip & ~sync2_q[i];
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        stab_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
      end else begin
        stab_cnt_q <= stab_cnt_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
      end
    end

`ifdef DEBOUNCE_REPEAT_EN
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_next, rep_target;
    logic             rep_armed_q, rep_armed_d;

    // rep_armed selects between the initial delay and the repeat period, so the
    // hold counter never has to count past max(REPEAT_DELAY, REPEAT_PERIOD).
    always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_armed_d = rep_armed_q;
      rep_fire    = 1'b0;
      rep_next    = rep_cnt_q + 1'b1;
      rep_target  = rep_armed_q ? REP_PERIOD_C : REP_DELAY_C;
      if (!level_q || flip) begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
      end else if (tick) begin
        if (rep_next == rep_target) begin
          rep_cnt_d   = '0;
          rep_armed_d = 1'b1;
          rep_fire    = 1'b1;
        end else begin
          rep_cnt_d = rep_next;
        end
      end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b0;
      end else begin
        rep_cnt_q   <= rep_cnt_d;
        rep_armed_q <= rep_armed_d;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign db_level[i]      = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Self-checking bench for multi_debounce: window-based reference model plus directed scenarios.
module tb_multi_debounce;

  localparam int CH = 4;
  localparam int CD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RP = 2;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic [CH-1:0] pb_in  = '0;
  logic [CH-1:0] db_level, press_pulse, release_pulse;
  logic          tick_out;

  int n_checks = 0;
  int n_fail   = 0;

  multi_debounce #(
    .CHANNELS      (CH),
    .CLK_DIV       (CD),
    .STABLE_TICKS  (ST),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .pb_in         (pb_in),
    .db_level      (db_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .tick_out      (tick_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  // Reference model: a level changes once the last ST tick samples all disagree with it;
  // auto-repeats are derived from the number of ticks held since the press.
  function automatic bit rep_due(input int h);
`ifdef DEBOUNCE_REPEAT_EN
    return (h == RD) || (h > RD && ((h - RD) % RP) == 0);
`else
    return 1'b0;
`endif
  endfunction

  int            k;
  bit            m_tick;
  logic [CH-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
  bit            win [CH][ST];
  int            hold [CH];
  bit            all_diff;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_tick = 0;
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
      for (int c = 0; c < CH; c++) begin
        hold[c] = 0;
        for (int j = 0; j < ST; j++) win[c][j] = 1'b0;
      end
    end else begin
      m_press = '0;
      m_rel   = '0;
      if (m_tick) begin
        for (int c = 0; c < CH; c++) begin
          for (int j = ST - 1; j > 0; j--) win[c][j] = win[c][j-1];
          win[c][0] = m_s2[c];
          all_diff = 1'b1;
          for (int j = 0; j < ST; j++) if (win[c][j] == m_lvl[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[c] = ~m_lvl[c];
            if (m_lvl[c]) m_press[c] = 1'b1;
            else          m_rel[c]   = 1'b1;
            hold[c] = 0;
          end else if (m_lvl[c]) begin
            hold[c]++;
            if (rep_due(hold[c])) m_press[c] = 1'b1;
          end
        end
      end
      m_s2   = m_s1;
      m_s1   = pb_in;
      k++;
      m_tick = ((k % CD) == 0);
    end
  end

  always @(posedge clk_in) begin
    #1;
    check("tick_out",      {31'b0, tick_out},    {31'b0, m_tick});
    check("db_level",      {28'b0, db_level},      {28'b0, m_lvl});
    check("press_pulse",   {28'b0, press_pulse},   {28'b0, m_press});
    check("release_pulse", {28'b0, release_pulse}, {28'b0, m_rel});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Waits up to limit cycles for press (sel=0) or release (sel=1) on channel ch; -1 on timeout.
  task automatic wait_pulse(input int ch, input bit sel, input int limit, output int cyc);
    cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      step(1);
      if ((sel ? release_pulse[ch] : press_pulse[ch]) === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int ch, input int n, output int pc, output int rc);
    pc = 0; rc = 0;
    for (int c = 0; c < n; c++) begin
      step(1);
      if (press_pulse[ch] === 1'b1)   pc++;
      if (release_pulse[ch] === 1'b1) rc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t_first, t_second, lat, lat0, lat2, pc, rc, act;

  initial begin
    // 1. Reset then idle
    step(3);
    check("reset_outputs", {db_level, press_pulse, release_pulse, 3'b0, tick_out}, 32'd0);
    @(negedge clk_in) rst_n = 1'b1;
    t_first = -1; t_second = -1; act = 0;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (tick_out === 1'b1) begin
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
      if ((press_pulse | release_pulse | db_level) != '0) act++;
    end
    check("first_tick_cycle",  t_first,  4);
    check("second_tick_cycle", t_second, 8);
    check("idle_activity",     act,      0);

    // 2. Clean press on ch0
    pb_in[0] = 1'b1;
    wait_pulse(0, 1'b0, 20, lat);
    check("press0_latency_ok", (lat >= 11 && lat <= 15), 1);
    check("press0_level",      db_level[0], 1);
    check("others_idle",       {29'b0, db_level[3:1]}, 0);
    step(1);
    check("press0_one_cycle",  press_pulse[0], 0);

    // 3. Bounce on ch1: toggles every 3 cycles, then settles high
    pc = 0;
    for (int s = 0; s < 10; s++) begin
      pb_in[1] = (s % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        step(1);
        if (press_pulse[1] === 1'b1) pc++;
      end
    end
    check("bounce_no_press", pc, 0);
    pb_in[1] = 1'b1;
    count_pulses(1, 20, pc, rc);
    check("settle_one_press",  pc, 1);
    check("settle_no_release", rc, 0);

    // 4. Simultaneous release of ch0 and ch2
    pb_in[2] = 1'b1;
    step(20);
    check("ch2_held", db_level[2], 1);
    pb_in[0] = 1'b0;
    pb_in[2] = 1'b0;
    lat0 = -1; lat2 = -1;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (release_pulse[0] === 1'b1 && lat0 < 0) lat0 = c;
      if (release_pulse[2] === 1'b1 && lat2 < 0) lat2 = c;
    end
    check("rel0_latency_ok", (lat0 >= 11 && lat0 <= 15), 1);
    check("rel_same_cycle",  lat0, lat2);
    count_pulses(0, 10, pc, rc);
    check("no_press_after_rel0", pc, 0);

    // 5. Async reset mid-window on ch3
    pb_in[1] = 1'b0;
    step(20);
    pb_in[3] = 1'b1;
    act = 0;
    for (int c = 0; c < 20 && act < 2; c++) begin
      step(1);
      if (tick_out === 1'b1) act++;
    end
    check("two_ticks_seen", act, 2);
    @(negedge clk_in) rst_n = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in) rst_n = 1'b1;
    check("ch3_cleared", db_level[3], 0);
    wait_pulse(3, 1'b0, 20, lat);
    check("ch3_press_after_reset", lat, 13);

    // 6. Auto-repeat on a held ch0
    pb_in[3] = 1'b0;
    step(20);
    pb_in[0] = 1'b1;
    wait_pulse(0, 1'b0, 20, lat);
    check("repeat_first_press_seen", (lat > 0), 1);
    count_pulses(0, 62, pc, rc);
`ifdef DEBOUNCE_REPEAT_EN
    check("repeat_press_count", pc + 1, 7);
`else
    check("repeat_press_count", pc + 1, 1);
`endif
    pb_in[0] = 1'b0;
    wait_pulse(0, 1'b1, 20, lat);
    check("repeat_release_seen", (lat > 0), 1);
    count_pulses(0, 20, pc, rc);
    check("no_trailing_repeat", pc, 0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
